// File: rtl/ap3_io_pkg.sv
// ============================================================================
// Module      : ap3_io_pkg
// Description : Shared IO-cell types, constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ap3_io_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_LEVEL_DFLT = 1'b0;

  // Counter width for a WIDTH-bit word; WIDTH-1 is the largest value held.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_ser_skid.sv
// ============================================================================
// Module      : out_ser_skid
// Description : One-entry word buffer in front of the output serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_ser_skid #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] loadData,
  input  logic             loadValid,
  output logic             loadReady,
  input  logic             push_en,
  input  logic             pop,
  output logic [WIDTH-1:0] bufData,
  output logic             bufValid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign loadReady = !valid_q;
  assign bufData   = data_q;
  assign bufValid  = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d = 1'b0;
    end else if (loadValid && loadReady && push_en) begin
      data_d  = loadData;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/out_ser_reg.sv
// ============================================================================
// Module      : out_ser_reg
// Description : Output IO cell: LSB-first parallel-to-serial pad driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_ser_reg
  import ap3_io_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] loadData,
  input  logic             loadValid,
  output logic             loadReady,
  input  logic             hold,
  input  logic             sel,
  input  logic             bypassIn,
  output logic             dataOut,
  output logic             outEn,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             oe_q, oe_d;

  logic [WIDTH-1:0] buf_data;
  logic             buf_valid;
  logic             push_en;
  logic             pop;
  logic             accept;
  logic             slot;
  logic [WIDTH-1:0] word;

  out_ser_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .loadData (loadData),
    .loadValid(loadValid),
    .loadReady(loadReady),
    .push_en  (push_en),
    .pop      (pop),
    .bufData  (buf_data),
    .bufValid (buf_valid)
  );

  assign accept = loadValid && loadReady;
  // A new word may start only when idle or when the last bit is on the pin.
  assign slot   = !hold && ((state_q == IDLE) || (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    push_en = 1'b1;
    pop     = 1'b0;
    word    = buf_valid ? buf_data : loadData;
    if (slot) begin
      push_en = 1'b0;
      if (buf_valid || accept) begin
        pop     = buf_valid;
        dout_d  = word[0];
        shreg_d = word >> 1;
        cnt_d   = CNT_W'(WIDTH - 1);
        oe_d    = 1'b1;
        state_d = SHIFT;
      end else begin
        dout_d  = IDLE_LEVEL;
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    end else if (!hold && (state_q == SHIFT)) begin
      dout_d  = shreg_q[0];
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= IDLE_LEVEL;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  assign dataOut = sel ? bypassIn : dout_q;
  assign outEn   = sel | oe_q;
  assign busy    = (state_q == SHIFT) | buf_valid;

endmodule

`default_nettype wire

// File: tb/tb_out_ser_reg.sv
// ============================================================================
// Module      : tb_out_ser_reg
// Description : Directed vector bench for out_ser_reg (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_ser_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] loadData;
  logic       loadValid;
  logic       loadReady;
  logic       hold;
  logic       sel;
  logic       bypassIn;
  logic       dataOut;
  logic       outEn;
  logic       busy;

  int applied = 0;
  int miscompares = 0;

  // Each row: drive inputs, let them settle, compare {dataOut,outEn,loadReady,busy}, then clock.
  typedef struct {
    logic [3:0] data;
    logic       valid;
    logic       hold;
    logic       sel;
    logic       byp;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  out_ser_reg #(
    .WIDTH(4),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .loadData (loadData),
    .loadValid(loadValid),
    .loadReady(loadReady),
    .hold     (hold),
    .sel      (sel),
    .bypassIn (bypassIn),
    .dataOut  (dataOut),
    .outEn    (outEn),
    .busy     (busy)
  );

  task automatic add(input logic [3:0] d, input logic v, input logic h,
                     input logic s, input logic b, input logic [3:0] e);
    vec_t r;
    r.data = d; r.valid = v; r.hold = h; r.sel = s; r.byp = b; r.exp = e;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {dataOut, outEn, loadReady, busy};
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: {dataOut,outEn,loadReady,busy} got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; loadData = '0; loadValid = 1'b0; hold = 1'b0; sel = 1'b0; bypassIn = 1'b0;

    // single word 1011
    add(4'hB, 1, 0, 0, 0, 4'b0010);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0010);
    // back-to-back A then 5 through the skid buffer
    add(4'hA, 1, 0, 0, 0, 4'b0010);
    add(4'h5, 1, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b1101);
    add(4'h0, 0, 0, 0, 0, 4'b0101);
    add(4'h0, 0, 0, 0, 0, 4'b1101);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b0010);
    // hold for 3 cycles while bit 1 of 1100 is on the pin
    add(4'hC, 1, 0, 0, 0, 4'b0010);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 1, 0, 0, 4'b0111);
    add(4'h0, 0, 1, 0, 0, 4'b0111);
    add(4'h0, 0, 1, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0010);
    // hold in IDLE: word 3 parks in the buffer
    add(4'h3, 1, 1, 0, 0, 4'b0010);
    add(4'h0, 0, 1, 0, 0, 4'b0001);
    add(4'h0, 0, 1, 0, 0, 4'b0001);
    add(4'h0, 0, 0, 0, 0, 4'b0001);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b0010);
    // bypass over word 0110 (shifter bits 0,1,1,0), then in IDLE
    add(4'h6, 1, 0, 0, 0, 4'b0010);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 1, 0, 4'b0111);
    add(4'h0, 0, 0, 1, 1, 4'b1111);
    add(4'h0, 0, 0, 0, 0, 4'b0111);
    add(4'h0, 0, 0, 0, 0, 4'b0010);
    add(4'h0, 0, 0, 1, 1, 4'b1110);
    add(4'h0, 0, 0, 0, 0, 4'b0010);

    // reset state, with and without bypass
    #2;
    chk("reset_state", 4'b0010);
    sel = 1'b1; bypassIn = 1'b1;
    #1;
    chk("reset_bypass", 4'b1110);
    sel = 1'b0; bypassIn = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      loadData  = vecs[i].data;
      loadValid = vecs[i].valid;
      hold      = vecs[i].hold;
      sel       = vecs[i].sel;
      bypassIn  = vecs[i].byp;
      #2;
      chk($sformatf("vec%0d", i), vecs[i].exp);
      tick();
    end
    loadValid = 1'b0; hold = 1'b0; sel = 1'b0; bypassIn = 1'b0;

    // bypass follows bypassIn within a cycle, no clock edge involved
    sel = 1'b1; bypassIn = 1'b0;
    #1; chk("byp_lo", 4'b0110);
    bypassIn = 1'b1;
    #1; chk("byp_hi", 4'b1110);
    sel = 1'b0;
    #1; chk("byp_off", 4'b0010);
    bypassIn = 1'b0;
    tick();

    // async reset while word D (1101) is on bit 2 and word 7 is buffered
    loadData = 4'hD; loadValid = 1'b1;
    tick();
    loadData = 4'h7;
    tick();
    loadValid = 1'b0;
    tick();
    #1; chk("pre_rst_bit2", 4'b1101);
    #1; rst = 1'b1;
    #1; chk("async_rst", 4'b0010);
    #1; rst = 1'b0;
    tick();
    chk("rst_discard", 4'b0010);

    loadData = 4'hF; loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; chk($sformatf("post_rst_F_bit%0d", k), 4'b1111);
      tick();
    end
    #1; chk("post_rst_idle", 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/out_ser_reg.md
Name: out_ser_reg

Overview:
- Output-direction IO cell: parallel-to-serial register driving an output pad plus its output-enable.
- Transmit counterpart of the input capture register. Fabric hands WIDTH-bit words over a valid/ready handshake; the cell shifts them out LSB-first, one bit per clock.
- One-word skid buffer allows gapless back-to-back streaming.
- Combinational bypass (sel) and a stall input (hold) match the input cell's controls.

Parameters:
- WIDTH, 4, bits per word; legal range 2..16.
- IDLE_LEVEL, 1'b0, value of the registered serial output when no word is being shifted.

Ports:
- clk  input  1  single clock; all state is posedge clk.
- rst  input  1  asynchronous, active-high reset.
- loadData  input  WIDTH  parallel word; bit 0 is transmitted first.
- loadValid  input  1  loadData valid.
- loadReady  output  1  cell can accept a word this cycle.
- hold  input  1  stall: freezes shifting, dataOut and outEn.
- sel  input  1  1 = bypass: dataOut follows bypassIn combinationally.
- bypassIn  input  1  bypass data.
- dataOut  output  1  serial data to the pad.
- outEn  output  1  pad output-enable.
- busy  output  1  a word is shifting or buffered.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, shift register and buffer cleared, bufValid=0, counter=0.
  - Registered output dout_q=IDLE_LEVEL, oe_q=0.
  - Ports: loadReady=1, busy=0, outEn=sel, dataOut=sel?bypassIn:IDLE_LEVEL.
- Reset asserted mid-word discards the shifter and buffer contents; no partial-word resume.
- Accept: accept = loadValid & loadReady. loadReady = !bufValid (combinational from a register only).
- States: IDLE, SHIFT. cnt is a $clog2(WIDTH)-bit counter of bits remaining after the bit currently on dout_q.
- IDLE, hold=0:
  - Start source = bufValid ? buf : (accept ? loadData : none).
  - On start: dout_q<=word[0], shreg<=word>>1, cnt<=WIDTH-1, oe_q<=1, state->SHIFT; clear bufValid if the buffer was used.
- IDLE, hold=1: an accepted word goes to buf (bufValid<=1). It starts on the first edge with hold=0.
- SHIFT, hold=1: shreg, cnt, dout_q, oe_q and state all frozen. Buffer may still accept.
- SHIFT, hold=0, cnt!=0: dout_q<=shreg[0], shreg>>=1, cnt<=cnt-1. An accept writes buf.
- SHIFT, hold=0, cnt==0 (last bit on the pin):
  - Next source = bufValid ? buf : (accept ? loadData : none).
  - With a source: reload as in the IDLE start and stay in SHIFT. Zero idle cycles between words.
  - Without a source: state->IDLE, dout_q<=IDLE_LEVEL, oe_q<=0.
- Latency: a word accepted on edge N in IDLE has bit k on dataOut during cycle N+k (k=0..WIDTH-1). outEn=1 from edge N to edge N+WIDTH.
- Simultaneous accept and buffer drain cannot occur: loadReady=0 whenever bufValid=1.
- busy = (state==SHIFT) | bufValid.
- Bypass:
  - sel=1: dataOut=bypassIn and outEn=1, combinational.
  - The internal shifter keeps running. sel does not gate the handshake.
  - When sel drops, the registered state is visible immediately.

Decomposition:
- Shared IO-cell package (ap3_io_pkg) holds:
  - state enum {IDLE, SHIFT};
  - localparam CNT_W = $clog2(WIDTH);
  - IDLE_LEVEL default constant.
- Natural sub-module: out_ser_skid, a one-entry buffer with loadData/loadValid/loadReady in and buf/bufValid/pop out.
- Shifter FSM and output muxing stay in out_ser_reg.

Test Plan:
1. Single word: WIDTH=4, reset, present loadData=4'b1011 for one accepted cycle -> dataOut 1,1,0,1 on consecutive cycles; outEn high exactly 4 cycles; then dataOut=0, busy=0.
2. Back-to-back: loadValid held with 4'hA then 4'h5 -> continuous 8-bit stream 0,1,0,1,1,0,1,0; outEn never drops; loadReady low while the buffer is full.
3. Hold stall: during 4'b1100, assert hold for 3 cycles after bit 1 -> dataOut holds 0 for those 3 extra cycles, then continues 1,1; total outEn duration 7 cycles.
4. Hold in IDLE: hold=1, accept 4'h3 -> no output, busy=1, loadReady=0; release hold -> 1,1,0,0 starts the next cycle.
5. Bypass: mid-word set sel=1, toggle bypassIn 0/1 -> dataOut mirrors bypassIn with zero latency, outEn=1; clear sel -> the shifter bit for that cycle is shown.
6. Async reset mid-word: assert rst between edges during bit 2 -> dataOut=0, outEn=0, loadReady=1 immediately without a clock edge; after release a new word 4'hF transmits cleanly.
